// File: rtl/f2_sdr_pkg.sv
// Shared definitions for the SDRAM port arbiter and the SDRAM controller.
package f2_sdr_pkg;

  localparam int SDR_AW   = 26;
  localparam int CPU_DW   = 16;
  localparam int SCN_DW   = 32;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_CPU = 2'd1,
    BUSY_SCN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sdram_port_arb_if.sv
// CPU, SCN and downstream SDRAM toggle-handshake bundle seen by the arbiter.
interface sdram_port_arb_if
  import f2_sdr_pkg::*;
  ;

  logic [SDR_AW:1]   cpu_addr;
  logic [CPU_DW-1:0] cpu_data;
  logic [1:0]        cpu_be;
  logic              cpu_rw;
  logic              cpu_req;
  logic              cpu_ack;
  logic [CPU_DW-1:0] cpu_q;

  logic [SDR_AW:1]   scn_addr;
  logic              scn_req;
  logic              scn_ack;
  logic [SCN_DW-1:0] scn_q;

  logic [SDR_AW:1]   sdr_addr;
  logic [CPU_DW-1:0] sdr_data;
  logic [1:0]        sdr_be;
  logic              sdr_rw;
  logic              sdr_wide;
  logic              sdr_req;
  logic              sdr_ack;
  logic [SCN_DW-1:0] sdr_q;

  // Arbiter side
  modport master (
    input  cpu_addr, cpu_data, cpu_be, cpu_rw, cpu_req,
    output cpu_ack, cpu_q,
    input  scn_addr, scn_req,
    output scn_ack, scn_q,
    output sdr_addr, sdr_data, sdr_be, sdr_rw, sdr_wide, sdr_req,
    input  sdr_ack, sdr_q
  );

  // Client and controller side
  modport slave (
    output cpu_addr, cpu_data, cpu_be, cpu_rw, cpu_req,
    input  cpu_ack, cpu_q,
    output scn_addr, scn_req,
    input  scn_ack, scn_q,
    input  sdr_addr, sdr_data, sdr_be, sdr_rw, sdr_wide, sdr_req,
    output sdr_ack, sdr_q
  );

endinterface

// File: rtl/sdr_toggle_port.sv
// One client port of the arbiter: pending detection, ack toggling and read-data capture.
module sdr_toggle_port #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic          done,
  input  logic          load,
  input  logic [DW-1:0] d,
  output logic          ack,
  output logic [DW-1:0] q,
  output logic          pending
);

  assign pending = req ^ ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack <= 1'b0;
      // NOTE: the read-data register is reset too, so a client never sees X before its first read.
      q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from before the edge.
      if (done) ack <= ~ack;
      if (load) q   <= d;
    end
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Two-port (CPU / SCN ROM) toggle-handshake arbiter in front of the SDRAM controller.
module sdram_port_arb
  import f2_sdr_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  sdram_port_arb_if.master bus
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e state, state_d;

  logic cpu_pend, scn_pend;
  logic cpu_grant, scn_grant;
  logic cpu_done, scn_done;
  logic scn_wins, sdr_acked;
  logic cpu_ack, scn_ack;
  logic [CPU_DW-1:0] cpu_q;
  logic [SCN_DW-1:0] scn_q;

  logic [STARVE_W-1:0] starve_cnt;
  logic [SDR_AW:1]     sdr_addr;
  logic [CPU_DW-1:0]   sdr_data;
  logic [1:0]          sdr_be;
  logic                sdr_rw;
  logic                sdr_wide;
  logic                sdr_req;

  sdr_toggle_port #(.DW(CPU_DW)) u_cpu_port (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.cpu_req),
    .done    (cpu_done),
    .load    (cpu_done & sdr_rw),
    .d       (bus.sdr_q[CPU_DW-1:0]),
    .ack     (cpu_ack),
    .q       (cpu_q),
    .pending (cpu_pend)
  );

  sdr_toggle_port #(.DW(SCN_DW)) u_scn_port (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.scn_req),
    .done    (scn_done),
    .load    (scn_done),
    .d       (bus.sdr_q),
    .ack     (scn_ack),
    .q       (scn_q),
    .pending (scn_pend)
  );

  assign sdr_acked = (bus.sdr_ack == sdr_req);
  assign scn_wins  = scn_pend && (starve_cnt == STARVE_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    state_d   = state;
    cpu_grant = 1'b0;
    scn_grant = 1'b0;
    cpu_done  = 1'b0;
    scn_done  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_pend && !scn_wins) begin
          cpu_grant = 1'b1;
          state_d   = BUSY_CPU;
        end else if (scn_pend) begin
          scn_grant = 1'b1;
          state_d   = BUSY_SCN;
        end
      end
      BUSY_CPU: begin
        if (sdr_acked) begin
          cpu_done = 1'b1;
          state_d  = IDLE;
        end
      end
      BUSY_SCN: begin
        if (sdr_acked) begin
          scn_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command fields are loaded only at grant and then held until the controller acknowledges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdr_addr <= '0;
      sdr_data <= '0;
      sdr_be   <= '0;
      sdr_rw   <= 1'b1;
      sdr_wide <= 1'b0;
      sdr_req  <= 1'b0;
    end else if (cpu_grant) begin
      sdr_addr <= bus.cpu_addr;
      sdr_data <= bus.cpu_data;
      sdr_be   <= bus.cpu_be;
      sdr_rw   <= bus.cpu_rw;
      sdr_wide <= 1'b0;
      sdr_req  <= ~sdr_req;
    end else if (scn_grant) begin
      sdr_addr <= bus.scn_addr;
      sdr_be   <= 2'b11;
      sdr_rw   <= 1'b1;
      sdr_wide <= 1'b1;
      sdr_req  <= ~sdr_req;
    end
  end

  // Counts CPU grants that jumped a waiting SCN request; saturates at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!scn_pend || scn_grant) begin
      starve_cnt <= '0;
    end else if (cpu_grant && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign bus.cpu_ack  = cpu_ack;
  assign bus.cpu_q    = cpu_q;
  assign bus.scn_ack  = scn_ack;
  assign bus.scn_q    = scn_q;
  assign bus.sdr_addr = sdr_addr;
  assign bus.sdr_data = sdr_data;
  assign bus.sdr_be   = sdr_be;
  assign bus.sdr_rw   = sdr_rw;
  assign bus.sdr_wide = sdr_wide;
  assign bus.sdr_req  = sdr_req;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb with a behavioural SDRAM controller on the downstream side.
module tb_sdram_port_arb;

  typedef struct {
    logic        is_scn;
    logic        rw;
    logic [25:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [31:0] q_ret;
    int          lat;
    logic        exp_wide;
    logic        exp_rw;
    logic [1:0]  exp_be;
    logic [15:0] exp_data;
    logic [31:0] exp_q;
  } vec_t;

  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   mem_lat;
  logic [31:0] mem_q;
  int   wait_cnt;
  vec_t vecs[6];

  sdram_port_arb_if bus();

  sdram_port_arb #(.STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream controller: acknowledges mem_lat cycles after seeing a request, data valid only then.
  initial begin
    bus.sdr_ack = 1'b0;
    bus.sdr_q   = GARBAGE;
    wait_cnt    = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bus.sdr_ack = 1'b0;
        bus.sdr_q   = GARBAGE;
        wait_cnt    = 0;
      end else if (bus.sdr_req != bus.sdr_ack) begin
        if (wait_cnt >= mem_lat) begin
          bus.sdr_ack = bus.sdr_req;
          bus.sdr_q   = mem_q;
          wait_cnt    = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        bus.sdr_q = GARBAGE;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset_n      = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.scn_req  = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data = '0;
    bus.cpu_be   = '0;
    bus.cpu_rw   = 1'b1;
    bus.scn_addr = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " sdr_req"},  {31'd0, bus.sdr_req},  32'd0);
    check({tag, " sdr_addr"}, {6'd0, bus.sdr_addr},  32'd0);
    check({tag, " sdr_data"}, {16'd0, bus.sdr_data}, 32'd0);
    check({tag, " sdr_be"},   {30'd0, bus.sdr_be},   32'd0);
    check({tag, " sdr_rw"},   {31'd0, bus.sdr_rw},   32'd1);
    check({tag, " sdr_wide"}, {31'd0, bus.sdr_wide}, 32'd0);
    check({tag, " cpu_ack"},  {31'd0, bus.cpu_ack},  32'd0);
    check({tag, " scn_ack"},  {31'd0, bus.scn_ack},  32'd0);
    check({tag, " cpu_q"},    {16'd0, bus.cpu_q},    32'd0);
    check({tag, " scn_q"},    bus.scn_q,             32'd0);
  endtask

  // One complete transaction on one port, checking issue fields, hold, latency and returned data.
  task automatic run_vec(input int idx, input vec_t v);
    logic  req0, ack0, other0;
    int    n;
    bit    stable;
    string t;
    t       = $sformatf("vec%0d", idx);
    mem_q   = v.q_ret;
    mem_lat = v.lat;
    req0    = bus.sdr_req;
    if (v.is_scn) begin
      ack0         = bus.scn_ack;
      other0       = bus.cpu_ack;
      bus.scn_addr = v.addr;
      bus.cpu_data = v.data;
      bus.scn_req  = ~bus.scn_req;
    end else begin
      ack0         = bus.cpu_ack;
      other0       = bus.scn_ack;
      bus.cpu_addr = v.addr;
      bus.cpu_data = v.data;
      bus.cpu_be   = v.be;
      bus.cpu_rw   = v.rw;
      bus.cpu_req  = ~bus.cpu_req;
    end
    @(negedge clk);
    check({t, " issue sdr_req"}, {31'd0, bus.sdr_req},  {31'd0, ~req0});
    check({t, " sdr_addr"},      {6'd0, bus.sdr_addr},  {6'd0, v.addr});
    check({t, " sdr_wide"},      {31'd0, bus.sdr_wide}, {31'd0, v.exp_wide});
    check({t, " sdr_rw"},        {31'd0, bus.sdr_rw},   {31'd0, v.exp_rw});
    check({t, " sdr_be"},        {30'd0, bus.sdr_be},   {30'd0, v.exp_be});
    check({t, " sdr_data"},      {16'd0, bus.sdr_data}, {16'd0, v.exp_data});
    // Client inputs change after grant; the issued command must not follow them.
    bus.cpu_addr = ~v.addr;
    bus.scn_addr = ~v.addr;
    bus.cpu_data = ~v.data;
    bus.cpu_be   = ~v.be;
    bus.cpu_rw   = ~v.rw;
    n      = 1;
    stable = 1'b1;
    while (((v.is_scn ? bus.scn_ack : bus.cpu_ack) == ack0) && n < 50) begin
      if (bus.sdr_addr != v.addr || bus.sdr_data != v.exp_data || bus.sdr_be != v.exp_be ||
          bus.sdr_rw != v.exp_rw || bus.sdr_wide != v.exp_wide || bus.sdr_req == req0)
        stable = 1'b0;
      @(negedge clk);
      n++;
    end
    check({t, " ack latency"}, n, v.lat + 2);
    check({t, " fields held"}, {31'd0, stable}, 32'd1);
    if (v.is_scn) begin
      check({t, " scn_q"},       bus.scn_q, v.exp_q);
      check({t, " cpu_ack idle"}, {31'd0, bus.cpu_ack}, {31'd0, other0});
    end else begin
      check({t, " cpu_q"},       {16'd0, bus.cpu_q}, v.exp_q);
      check({t, " scn_ack idle"}, {31'd0, bus.scn_ack}, {31'd0, other0});
    end
    check({t, " single sdr_req toggle"}, {31'd0, bus.sdr_req}, {31'd0, ~req0});
  endtask

  // Both ports re-request as soon as served; records which port each downstream issue belongs to.
  task automatic run_arb();
    logic       prev, c_ack, s_ack;
    logic [9:0] grants;
    int         g, cyc;
    mem_lat = 0;
    mem_q   = 32'h0000_5555;
    grants  = '0;
    g       = 0;
    cyc     = 0;
    prev    = bus.sdr_req;
    c_ack   = bus.cpu_ack;
    s_ack   = bus.scn_ack;
    bus.cpu_rw  = 1'b1;
    bus.cpu_req = ~bus.cpu_req;
    bus.scn_req = ~bus.scn_req;
    while (g < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.sdr_req != prev) begin
        prev      = bus.sdr_req;
        grants[g] = bus.sdr_wide;
        g++;
      end
      if (g < 10) begin
        if (bus.cpu_ack != c_ack) begin
          c_ack       = bus.cpu_ack;
          bus.cpu_req = ~bus.cpu_req;
        end
        if (bus.scn_ack != s_ack) begin
          s_ack       = bus.scn_ack;
          bus.scn_req = ~bus.scn_req;
        end
      end
    end
    check("arb grant count", g, 10);
    for (int i = 0; i < g; i++)
      check($sformatf("arb grant %0d is scn", i), {31'd0, grants[i]}, (i % 5 == 4) ? 32'd1 : 32'd0);
    cyc = 0;
    while ((bus.cpu_req != bus.cpu_ack || bus.scn_req != bus.scn_ack) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("arb drain", {31'd0, cyc < 50}, 32'd1);
  endtask

  initial begin
    vec_t fresh;
    checks  = 0;
    errors  = 0;
    mem_lat = 0;
    mem_q   = GARBAGE;

    reset_n      = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.scn_req  = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data = '0;
    bus.cpu_be   = '0;
    bus.cpu_rw   = 1'b1;
    bus.scn_addr = '0;
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset starve_cnt", {28'd0, dut.starve_cnt}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    //          scn   rw    addr          data      be     q_ret          lat wide  rw    be     data      exp_q
    vecs[0] = '{1'b0, 1'b1, 26'h0000100, 16'h0BAD, 2'b11, 32'hCAFE_1234, 0, 1'b0, 1'b1, 2'b11, 16'h0BAD, 32'h0000_1234};
    vecs[1] = '{1'b0, 1'b0, 26'h0000200, 16'hA55A, 2'b01, 32'h9999_8888, 2, 1'b0, 1'b0, 2'b01, 16'hA55A, 32'h0000_1234};
    vecs[2] = '{1'b1, 1'b1, 26'h0200000, 16'h7777, 2'b00, 32'h1122_3344, 1, 1'b1, 1'b1, 2'b11, 16'hA55A, 32'h1122_3344};
    vecs[3] = '{1'b0, 1'b1, 26'h3FFFFFF, 16'hFFFF, 2'b10, 32'h0000_ABCD, 3, 1'b0, 1'b1, 2'b10, 16'hFFFF, 32'h0000_ABCD};
    vecs[4] = '{1'b1, 1'b1, 26'h0000001, 16'h0000, 2'b00, 32'hFFFF_0000, 0, 1'b1, 1'b1, 2'b11, 16'hFFFF, 32'hFFFF_0000};
    vecs[5] = '{1'b0, 1'b0, 26'h0123456, 16'h1357, 2'b10, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 2'b10, 16'h1357, 32'h0000_ABCD};
    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
      @(negedge clk);
    end

    run_arb();

    // Simultaneous first requests: CPU first with the SCN wait counted, then SCN.
    apply_reset();
    mem_lat     = 0;
    mem_q       = 32'h0000_4242;
    bus.cpu_req = 1'b1;
    bus.scn_req = 1'b1;
    @(negedge clk);
    check("first sdr_req",    {31'd0, bus.sdr_req},  32'd1);
    check("first is cpu",     {31'd0, bus.sdr_wide}, 32'd0);
    check("first starve_cnt", {28'd0, dut.starve_cnt}, 32'd1);
    @(negedge clk);
    check("first cpu_ack",    {31'd0, bus.cpu_ack},  32'd1);
    check("first scn waits",  {31'd0, bus.scn_ack},  32'd0);
    check("turnaround idle",  {31'd0, bus.sdr_req},  32'd1);
    @(negedge clk);
    check("second sdr_req",   {31'd0, bus.sdr_req},  32'd0);
    check("second is scn",    {31'd0, bus.sdr_wide}, 32'd1);
    check("starve cleared",   {28'd0, dut.starve_cnt}, 32'd0);
    @(negedge clk);
    check("second scn_ack",   {31'd0, bus.scn_ack},  32'd1);
    check("second scn_q",     bus.scn_q, 32'h0000_4242);

    // Reset while an SCN burst is outstanding: outputs clear at once and the burst is dropped.
    apply_reset();
    @(negedge clk);
    mem_lat      = 30;
    bus.scn_addr = 26'h0300000;
    bus.scn_req  = 1'b1;
    @(negedge clk);
    check("busy scn issued", {31'd0, bus.sdr_wide}, 32'd1);
    @(negedge clk);
    #2;
    reset_n     = 1'b0;
    bus.scn_req = 1'b0;
    #1;
    check_reset_outputs("async reset");
    repeat (3) @(negedge clk);
    check("abandoned scn_ack", {31'd0, bus.scn_ack}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post reset scn_ack", {31'd0, bus.scn_ack}, 32'd0);
    fresh = '{1'b1, 1'b1, 26'h0000040, 16'h0000, 2'b00, 32'h5A5A_0F0F, 0, 1'b1, 1'b1, 2'b11, 16'h0000, 32'h5A5A_0F0F};
    run_vec(6, fresh);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive CPU grants while an SCN request is pending (range 1-15).
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  reset; asynchronous assert, active-low (fixed decision).
REQ-004 cpu_addr  in  26 [26:1]  CPU word address.
REQ-005 cpu_data  in  16  CPU write data.
REQ-006 cpu_be  in  2  byte enables, [1]=upper.
REQ-007 cpu_rw  in  1  1=read, 0=write.
REQ-008 cpu_req  in  1  toggle request.
REQ-009 cpu_ack  out  1  toggle acknowledge.
REQ-010 cpu_q  out  16  CPU read data.
REQ-011 scn_addr  in  26 [26:1]  SCN ROM address, read-only port.
REQ-012 scn_req  in  1  toggle request.
REQ-013 scn_ack  out  1  toggle acknowledge.
REQ-014 scn_q  out  32  SCN read data.
REQ-015 sdr_addr/sdr_data/sdr_be/sdr_rw  out  26/16/2/1  downstream command fields.
REQ-016 sdr_wide  out  1  1=32-bit read burst, 0=16-bit access.
REQ-017 sdr_req  out  1  downstream toggle request.
REQ-018 sdr_ack  in  1  downstream toggle acknowledge.
REQ-019 sdr_q  in  32  downstream read data; valid in the cycle sdr_ack is seen equal to sdr_req.

Function
REQ-020 A port is pending when its req differs from its ack; toggling req again while pending is a protocol violation and is ignored.
REQ-021 FSM states are IDLE, BUSY_CPU and BUSY_SCN.
REQ-022 In IDLE with any port pending, the next edge latches the winner's fields onto sdr_*, toggles sdr_req and enters BUSY_<winner>.
REQ-023 Issued fields: CPU -> sdr_wide=0 with its own addr/data/be/rw; SCN -> sdr_wide=1, sdr_rw=1, sdr_be=2'b11, sdr_data unchanged.
REQ-024 Arbitration: CPU wins unless SCN is pending and starve_cnt equals STARVE_LIMIT; then SCN wins.
REQ-025 starve_cnt (4 bits) increments on each CPU grant while SCN is pending; it clears on an SCN grant or when SCN is not pending; it saturates at STARVE_LIMIT.
REQ-026 In BUSY_x, when sdr_ack equals sdr_req, the next edge does the following: register sdr_q into x_q (cpu_q takes sdr_q[15:0], and only on reads), toggle x_ack, return to IDLE.
REQ-027 For CPU writes, cpu_q holds its previous value; cpu_ack still toggles.
REQ-028 sdr_* fields hold stable from issue until the acknowledge; client inputs are sampled only at grant.
REQ-029 Minimum turnaround: one IDLE cycle between acknowledge completion and the next issue; issue latency from pending detection is 1 clk.
REQ-030 No second downstream request is outstanding at any time; sdr_req toggles at most once per transaction.
REQ-031 A request arriving in the same cycle its own ack toggles is seen pending in IDLE and served normally.

Reset
REQ-032 On reset_n low, immediately: state=IDLE, cpu_ack=0, scn_ack=0, sdr_req=0, starve_cnt=0, cpu_q=0, scn_q=0, sdr_addr=0, sdr_data=0, sdr_be=0, sdr_rw=1, sdr_wide=0.
REQ-033 A transaction in flight at reset is abandoned; no ack toggles for it, and the downstream controller is reset by the same reset_n.

Structure
REQ-034 Package f2_sdr_pkg shall hold the FSM state enum, SDR_AW=26, CPU_DW=16 and SCN_DW=32; the package is shared with the SDRAM controller.
REQ-035 One sub-module, sdr_toggle_port, shall provide per-port pending detection and ack toggling; it is instantiated twice.

Verification
REQ-036 CPU read of addr 0x000100 with sdr_q=0xCAFE1234 -> sdr_wide=0, sdr_rw=1, sdr_req toggles 1 clk after cpu_req; cpu_q=0x1234 and cpu_ack toggles 1 clk after sdr_ack.
REQ-037 CPU write of data 0xA55A with be=2'b01 -> sdr_data=0xA55A, sdr_be=01, sdr_rw=0; cpu_q unchanged and cpu_ack toggles.
REQ-038 SCN read of addr 0x200000 with sdr_q=0x11223344 -> sdr_wide=1, sdr_be=11; scn_q=0x11223344 and scn_ack toggles.
REQ-039 Both ports requesting every cycle with STARVE_LIMIT=4 -> grant order CPU,CPU,CPU,CPU,SCN, repeating.
REQ-040 reset_n pulsed low while in BUSY_SCN before sdr_ack -> all outputs at reset values asynchronously; scn_ack stays 0; a fresh request after release completes.
REQ-041 Simultaneous first requests after reset with starve_cnt=0 -> CPU served first, then SCN with starve_cnt=1 before clearing.
